product_accumulator: RTL and testbench
======================================

# product_accumulator

Downstream consumer of the array multiplier's `Z_final`/`o_valid` stream. It sums a fixed-length group of `ACC_LEN` products into one result and buffers completed results in a 2-entry output queue. The queue drains under a valid/ready handshake. The multiplier cannot be stalled, so the block never back-pressures its input; a result that finds the queue full is dropped and flagged.

## Interface
Parameters:
- `DATAWIDTH`, 4: multiplier operand width; product width is 2*`DATAWIDTH`.
- `ACC_LEN`, 4: products per group; must be ≥2.
- `ACCWIDTH`, 2*`DATAWIDTH`+$clog2(`ACC_LEN`): result width, derived; never overridden.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  product valid, driven by the multiplier `o_valid`.
- `i_product`  in  2*`DATAWIDTH`  product, driven by the multiplier `Z_final`.
- `i_clear`  in  1  discards the partial group.
- `o_valid`  out  1  queue head valid.
- `o_ready`  in  1  downstream accepts the head.
- `o_sum`  out  `ACCWIDTH`  queue head value.
- `o_count`  out  $clog2(`ACC_LEN`+1)  products in the current partial group.
- `o_overflow`  out  1  sticky; set when a completed result is dropped.

## Operation
- Group FSM states:
  - ACC_IDLE: `o_count`=0, accumulator=0.
  - ACC_RUN: 1 ≤ `o_count` < `ACC_LEN`.
- Accepting products:
  - `i_valid`=1 accepts the product in that cycle, unconditionally.
  - `i_product` is zero-extended to `ACCWIDTH` before adding. No saturation is needed, because `ACCWIDTH` covers `ACC_LEN`·(2^(2·DW)−1).
- Group completion:
  - When the accepted product is the `ACC_LEN`-th, the sum (accumulator + product) is pushed to the queue.
  - The accumulator and count then return to 0 (ACC_IDLE) in the same edge.
- Gaps: `i_valid` gaps of any length are allowed; the partial state holds.
- `i_clear` rules:
  - With `i_valid`=0: the partial state is zeroed (→ACC_IDLE).
  - With `i_valid`=1: the partial state is discarded and the current product starts a new group (count=1, acc=product).
  - When `ACC_LEN`=1-completion cannot occur on a clear cycle.
  - The queue is unaffected by `i_clear`.
- Output queue:
  - 2 entries, FIFO order.
  - Pop occurs when `o_valid`&&`o_ready`.
  - Push and pop in the same cycle are both honoured, including when the queue is full; the pop frees the slot.
  - A push when the queue is full without a same-cycle pop drops the new result, keeps the queued ones, and sets `o_overflow`.
- `o_overflow` clears only on `rst`.
- `o_sum` is stable while `o_valid`=1 and `o_ready`=0.

## Timing
- Reset values: `o_valid`=0, `o_sum`=0, `o_count`=0, `o_overflow`=0; FSM in ACC_IDLE; queue empty.
- Reset mid-group or with the queue occupied discards everything; reset has priority over all other inputs.
- Latency:
  - `o_valid` rises in the cycle after the completing product's `i_valid` edge.
  - `o_count` updates in the cycle after each accepted product.
- Throughput: one product per cycle sustained. With `o_ready`=1 the block emits one result every `ACC_LEN` cycles and never drops.
- Registered outputs: the queue head and flags are registered. There is no combinational path from `i_valid`/`i_product` to `o_valid`/`o_sum`. `o_ready` affects the next-state logic only.

## Structure
- Package `product_accumulator_pkg`:
  - `acc_state_t` enum {ACC_IDLE, ACC_RUN}
  - constant `RESULT_Q_DEPTH`=2
  - function for `ACCWIDTH` derivation.
- Sub-module `result_queue`:
  - parameterised 2-entry synchronous FIFO on `ACCWIDTH`.
  - ports: push/data/full, pop/head/empty.
  - implements the simultaneous push/pop-when-full rule.
- Top: FSM, counter, adder, overflow flag.

## Test plan
- DW=4, ACC_LEN=4, `o_ready`=1. Stimulus: four back-to-back products of 225. Expect `o_valid`=1 with `o_sum`=900 exactly one cycle after the 4th; `o_count` sequence 1,2,3,0.
- Gapped input. Stimulus: products 1,2,3,4 with 3 idle cycles between each. Expect `o_sum`=10, and `o_count` holds during the gaps.
- Clear. Stimulus: 10,20, then `i_clear` with `i_valid` and product 5, then 6,7,8. Expect `o_sum`=26; the 10 and 20 never appear.
- Backpressure. Stimulus: `o_ready`=0 while three groups of all-1 products complete. Expect the queue to hold 4,4 and `o_overflow`=1 after the 3rd completion. After raising `o_ready`, exactly two results pop, and `o_overflow` stays 1.
- Full-queue push+pop. Stimulus: queue full, then `o_ready`=1 on the same cycle a 3rd group completes. Expect no overflow; three results emerge in order.
- Reset mid-group. Stimulus: two products accepted and one result queued, then `rst` for 1 cycle. Expect all outputs 0 the next cycle, and the next group to sum from zero.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// product_accumulator_pkg: shared types, queue depth and result-width helper
package product_accumulator_pkg;
  typedef enum logic {ACC_IDLE, ACC_RUN} acc_state_t;
  localparam int RESULT_Q_DEPTH = 2;
  function automatic int acc_width(input int dw, input int len);
    return 2 * dw + $clog2(len);
  endfunction
endpackage

// File: rtl/result_queue.sv
// result_queue: 2-entry shift FIFO honouring push+pop together even when full
module result_queue
  import product_accumulator_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o
);
  localparam int CW = $clog2(RESULT_Q_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(RESULT_Q_DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic pop, push;
  always_comb begin
    pop = pop_i && cnt_q != '0;
    push = push_i && (cnt_q != FULL || pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    head_d = (pop && cnt_q == FULL) ? tail_q
           : (push && (cnt_q == '0 || (pop && cnt_q == ONE))) ? data_i : head_q;
    tail_d = (push && ((cnt_q == ONE && !pop) || (cnt_q == FULL && pop))) ? data_i : tail_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
  assign full_o = cnt_q == FULL;
  assign empty_o = cnt_q == '0;
  assign head_o = head_q;
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums ACC_LEN products per group into a 2-entry result queue
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int DATAWIDTH = 4,
  parameter int ACC_LEN = 4,
  parameter int ACCWIDTH = acc_width(DATAWIDTH, ACC_LEN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  input  logic [2*DATAWIDTH-1:0]       i_product,
  input  logic                         i_clear,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [ACCWIDTH-1:0]          o_sum,
  output logic [$clog2(ACC_LEN+1)-1:0] o_count,
  output logic                         o_overflow
);
  localparam int CW = $clog2(ACC_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);
  acc_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, base_cnt;
  logic [ACCWIDTH-1:0] acc_q, acc_d, base_acc, sum;
  logic ovf_q, done, full, empty, drop;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC_IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      ovf_q <= ovf_q | drop;
    end
  end
  always_comb begin
    base_cnt = (i_clear || state_q == ACC_IDLE) ? '0 : cnt_q;
    base_acc = (i_clear || state_q == ACC_IDLE) ? '0 : acc_q;
    sum = base_acc + {{(ACCWIDTH-2*DATAWIDTH){1'b0}}, i_product};
    done = i_valid && base_cnt == LAST;
    cnt_d = !i_valid ? base_cnt : done ? '0 : base_cnt + CW'(1);
    acc_d = !i_valid ? base_acc : done ? '0 : sum;
    state_d = cnt_d == '0 ? ACC_IDLE : ACC_RUN;
    drop = done && full && !(o_ready && !empty);
  end
  always_comb begin
    o_count = cnt_q;
    o_valid = !empty;
    o_overflow = ovf_q;
  end
  result_queue #(.W(ACCWIDTH)) u_queue (
    .clk(clk),
    .rst(rst),
    .push_i(done),
    .data_i(sum),
    .full_o(full),
    .pop_i(o_ready),
    .head_o(o_sum),
    .empty_o(empty)
  );
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed vectors with a queue scoreboard and handshake monitor
module tb_product_accumulator;
  logic clk = 0, rst = 1, i_valid = 0, i_clear = 0, o_ready = 1;
  logic [7:0] i_product = 0;
  logic o_valid, o_overflow;
  logic [9:0] o_sum;
  logic [2:0] o_count;
  int tests = 0, fails = 0;
  int exp_q[$];
  product_accumulator #(.DATAWIDTH(4), .ACC_LEN(4)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_product(i_product), .i_clear(i_clear),
    .o_valid(o_valid), .o_ready(o_ready), .o_sum(o_sum), .o_count(o_count), .o_overflow(o_overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst && o_valid && o_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got o_sum=%0d, required no result", o_sum);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(o_sum) != e) begin
          fails++;
          $display("FAIL pop_sum: got %0d, required %0d", o_sum, e);
        end
      end
    end
  end
  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask
  task automatic put(input int p, input bit clr);
    i_valid = 1;
    i_product = 8'(p);
    i_clear = clr;
    @(posedge clk); #1;
    i_valid = 0;
    i_clear = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask
  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin @(posedge clk); #1; k++; end
    chk(name, exp_q.size(), 0);
  endtask
  initial begin
    @(posedge clk); #1;
    do_reset();
    chk("rst_valid", o_valid, 0);
    chk("rst_sum", o_sum, 0);
    chk("rst_count", o_count, 0);
    chk("rst_ovf", o_overflow, 0);
    exp_q.push_back(900);
    put(225, 0); chk("b2b_cnt1", o_count, 1);
    put(225, 0); chk("b2b_cnt2", o_count, 2);
    put(225, 0); chk("b2b_cnt3", o_count, 3);
    put(225, 0); chk("b2b_cnt0", o_count, 0);
    chk("b2b_valid", o_valid, 1);
    idle(1);
    chk("b2b_popped", o_valid, 0);
    exp_q.push_back(10);
    for (int i = 1; i <= 4; i++) begin
      put(i, 0);
      idle(3);
      chk("gap_hold", o_count, i % 4);
    end
    drain("gap_drain");
    exp_q.push_back(26);
    put(10, 0);
    put(20, 0);
    put(5, 1); chk("clr_cnt", o_count, 1);
    put(6, 0);
    put(7, 0);
    put(8, 0);
    drain("clr_drain");
    o_ready = 0;
    exp_q.push_back(4);
    exp_q.push_back(4);
    for (int g = 0; g < 3; g++) begin
      repeat (4) put(1, 0);
      if (g == 1) chk("bp_ovf_before", o_overflow, 0);
    end
    chk("bp_ovf", o_overflow, 1);
    chk("bp_valid", o_valid, 1);
    chk("bp_head", o_sum, 4);
    o_ready = 1;
    idle(4);
    chk("bp_left", exp_q.size(), 0);
    chk("bp_empty", o_valid, 0);
    chk("bp_ovf_sticky", o_overflow, 1);
    do_reset();
    chk("fp_ovf_rst", o_overflow, 0);
    o_ready = 0;
    exp_q.push_back(4);
    exp_q.push_back(8);
    exp_q.push_back(12);
    repeat (4) put(1, 0);
    repeat (4) put(2, 0);
    repeat (3) put(3, 0);
    o_ready = 1;
    put(3, 0);
    chk("fp_no_ovf", o_overflow, 0);
    chk("fp_head", o_sum, 8);
    drain("fp_drain");
    chk("fp_ovf_end", o_overflow, 0);
    o_ready = 0;
    repeat (4) put(1, 0);
    put(5, 0);
    put(5, 0);
    chk("rm_cnt_pre", o_count, 2);
    chk("rm_valid_pre", o_valid, 1);
    do_reset();
    chk("rm_valid", o_valid, 0);
    chk("rm_sum", o_sum, 0);
    chk("rm_count", o_count, 0);
    chk("rm_ovf", o_overflow, 0);
    o_ready = 1;
    exp_q.push_back(10);
    for (int i = 1; i <= 4; i++) put(i, 0);
    drain("rm_drain");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end
endmodule
